instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  downstream cannot accept current instruction.
REQ-006 SHALL have port redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  in  32  redirect target byte address.
REQ-008 SHALL have port imem_addr  out  32  byte address to synchronous IMEM, driven from pc_q register.
REQ-009 SHALL have port imem_en  out  1  IMEM read enable; data valid on imem_rdata the cycle after an enabled read.
REQ-010 SHALL have port imem_rdata  in  32  IMEM read data.
REQ-011 SHALL have port inst  out  32  instruction to control logic / decode.
REQ-012 SHALL have port inst_pc  out  32  address of inst.
REQ-013 SHALL have port inst_valid  out  1  inst is a real instruction (not bubble).
REQ-014 SHALL have port fetch_count  out  32  count of instructions accepted downstream.

Function
REQ-015 SHALL keep registers pc_q (next fetch addr), inflight_pc (addr of data arriving this cycle), hold_inst, hold_pc, state in {REFILL, RUN, STALL}.
REQ-016 imem_addr SHALL equal pc_q in every state; pc_q[1:0] SHALL always be 2'b00.
REQ-017 REFILL, stall=0, redirect=0: imem_en=1, inst=NOP_INST, inst_pc=0, inst_valid=0; next: inflight_pc<=pc_q, pc_q<=pc_q+4, state RUN.
REQ-018 REFILL, stall=1, redirect=0: imem_en=0, bubble outputs, all registers hold.
REQ-019 RUN, stall=0, redirect=0: imem_en=1, inst=imem_rdata, inst_pc=inflight_pc, inst_valid=1; next: inflight_pc<=pc_q, pc_q<=pc_q+4.
REQ-020 RUN, stall=1, redirect=0: outputs as REQ-019, imem_en=0; next: hold_inst<=imem_rdata, hold_pc<=inflight_pc, pc_q holds, state STALL.
REQ-021 STALL: inst=hold_inst, inst_pc=hold_pc, inst_valid=1; stall=1 -> imem_en=0, hold all; stall=0 -> imem_en=1, inflight_pc<=pc_q, pc_q<=pc_q+4, state RUN (zero bubbles on release).
REQ-022 redirect=1 in any state SHALL override stall: imem_en=0; next: pc_q<={redirect_pc[31:2],2'b00}, state REFILL; outputs this cycle per current state.
REQ-023 Steady-state latency: instruction at address A SHALL appear on inst one cycle after imem_addr=A with imem_en=1.
REQ-024 Redirect penalty SHALL be exactly one bubble cycle (REFILL) before target instruction is valid.
REQ-025 pc_q+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 fetch_count SHALL increment by 1 each cycle with inst_valid=1, stall=0, redirect=0; wraps 32'hFFFF_FFFF -> 0.
REQ-027 redirect asserted on consecutive cycles SHALL keep state REFILL and take the latest redirect_pc.

Reset
REQ-028 rst_n=0 SHALL immediately force pc_q=RESET_PC, inflight_pc=0, hold_inst=NOP_INST, hold_pc=0, fetch_count=0, state REFILL.
REQ-029 During reset outputs SHALL be imem_en=0, imem_addr=RESET_PC, inst=NOP_INST, inst_pc=0, inst_valid=0, fetch_count=0; reset mid-stall or mid-redirect discards all in-flight state.
REQ-030 First cycle after rst_n rises SHALL fetch RESET_PC (REFILL behaviour).

Structure
REQ-031 NOP_INST and the state encodings SHALL live in the shared RISC-V constants header alongside opcode definitions.
REQ-032 Block SHALL be a single module; no sub-module; inst output feeds control_logic instruction input directly.

Verification
REQ-033 Reset release, IMEM model returns addr as data -> cycle1 inst=32'h4000_0000, inst_pc=32'h4000_0000, valid=1; cycle2 inst_pc=32'h4000_0004.
REQ-034 stall high 3 cycles in RUN with inst_pc=32'h4000_0008 -> inst/inst_pc held 4 cycles, imem_en=0 while stalled, next inst_pc=32'h4000_000C, fetch_count +1 only on release.
REQ-035 redirect=1, redirect_pc=32'h4000_0103 -> next cycle valid=0, inst=32'h0000_0013; following cycle inst_pc=32'h4000_0100.
REQ-036 redirect and stall both high -> REFILL entered, stall ignored, target fetched once stall low.
REQ-037 redirect to 32'hFFFF_FFFC -> inst_pc sequence 32'hFFFF_FFFC, 32'h0000_0000.
REQ-038 rst_n low during STALL -> outputs immediately at reset values, fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared RISC-V constants and fetch state encodings
package instruction_fetch_unit_pkg;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bubble instruction: addi x0,x0,0
  localparam logic [31:0] NOP_INST = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  // Fetch pipeline states
  typedef enum logic [1:0] {
    ST_REFILL = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2
  } fetch_state_e;

  // Force a byte address onto a 32-bit instruction boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    logic [31:0] tmp;
    tmp = addr;
    tmp[1:0] = 2'b00;
    return tmp;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - synchronous IMEM read bus
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-issue fetch stage for a synchronous IMEM
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = instruction_fetch_unit_pkg::NOP_INST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  instruction_fetch_unit_if.master      imem,
  output logic [31:0]                   inst,
  output logic [31:0]                   inst_pc,
  output logic                          inst_valid,
  output logic [31:0]                   fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         fetch_en;

  // Output selection: bubble while refilling, live IMEM data while running, held copy while stalled
  always_comb begin
    inst       = NOP_INST;
    inst_pc    = 32'h0;
    inst_valid = 1'b0;
    fetch_en   = 1'b0;
    case (state_q)
      ST_REFILL: begin
        fetch_en = ~stall & ~redirect;
      end
      ST_RUN: begin
        inst       = imem.imem_rdata;
        inst_pc    = inflight_pc_q;
        inst_valid = 1'b1;
        fetch_en   = ~stall & ~redirect;
      end
      ST_STALL: begin
        inst       = hold_inst_q;
        inst_pc    = hold_pc_q;
        inst_valid = 1'b1;
        fetch_en   = ~stall & ~redirect;
      end
      default: begin
        fetch_en = 1'b0;
      end
    endcase
  end

  // The IMEM enable is gated by reset so the memory sees no reads while held in reset
  assign imem.imem_en   = fetch_en & rst_n;
  assign imem.imem_addr = pc_q;
  assign fetch_count    = fetch_count_q;

  // Next-state logic: redirect wins over stall, an enabled fetch always advances the PC
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      pc_d    = word_align(redirect_pc);
      state_d = ST_REFILL;
    end else begin
      if (fetch_en) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
        state_d       = ST_RUN;
      end else if (state_q == ST_RUN) begin
        // Capture the instruction now: IMEM data is only valid for this one cycle
        hold_inst_d = imem.imem_rdata;
        hold_pc_d   = inflight_pc_q;
        state_d     = ST_STALL;
      end
      if (inst_valid && !stall) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  // State registers; reset discards any in-flight or held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REFILL;
      pc_q          <= word_align(RESET_PC);
      inflight_pc_q <= 32'h0;
      hold_inst_q   <= NOP_INST;
      hold_pc_q     <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST = 32'h4000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [31:0] fetch_count;

  int total;
  int bad;

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM model: data returned is the address that was read, one cycle later
  always @(posedge clk) begin
    if (imem.imem_en) imem.imem_rdata <= imem.imem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let outputs settle
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem.imem_rdata = 32'h0;

    // Reset state
    step(0, 0, 0);
    chk("rst_en",    {31'd0, imem.imem_en}, 32'd0);
    chk("rst_addr",  imem.imem_addr, RST);
    chk("rst_inst",  inst, NOP);
    chk("rst_pc",    inst_pc, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);

    // Release reset: REFILL fetches RESET_PC
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("refill_en",    {31'd0, imem.imem_en}, 32'd1);
    chk("refill_addr",  imem.imem_addr, RST);
    chk("refill_valid", {31'd0, inst_valid}, 32'd0);

    // First two instructions
    step(0, 0, 0);
    chk("c1_inst",  inst, 32'h4000_0000);
    chk("c1_pc",    inst_pc, 32'h4000_0000);
    chk("c1_valid", {31'd0, inst_valid}, 32'd1);
    chk("c1_addr",  imem.imem_addr, 32'h4000_0004);
    step(0, 0, 0);
    chk("c2_pc",  inst_pc, 32'h4000_0004);
    chk("c2_cnt", fetch_count, 32'd1);

    // Stall three cycles on 4000_0008
    step(1, 0, 0);
    chk("s1_pc",   inst_pc, 32'h4000_0008);
    chk("s1_inst", inst, 32'h4000_0008);
    chk("s1_en",   {31'd0, imem.imem_en}, 32'd0);
    chk("s1_cnt",  fetch_count, 32'd2);
    step(1, 0, 0);
    chk("s2_inst", inst, 32'h4000_0008);
    chk("s2_en",   {31'd0, imem.imem_en}, 32'd0);
    step(1, 0, 0);
    chk("s3_pc",   inst_pc, 32'h4000_0008);
    chk("s3_cnt",  fetch_count, 32'd2);
    step(0, 0, 0);
    chk("s4_inst", inst, 32'h4000_0008);
    chk("s4_en",   {31'd0, imem.imem_en}, 32'd1);
    chk("s4_addr", imem.imem_addr, 32'h4000_000C);
    step(0, 0, 0);
    chk("s5_pc",    inst_pc, 32'h4000_000C);
    chk("s5_inst",  inst, 32'h4000_000C);
    chk("s5_cnt",   fetch_count, 32'd3);

    // Redirect to an unaligned target
    step(0, 1, 32'h4000_0103);
    chk("rd_en",  {31'd0, imem.imem_en}, 32'd0);
    chk("rd_pc",  inst_pc, 32'h4000_0010);
    chk("rd_cnt", fetch_count, 32'd4);
    step(0, 0, 0);
    chk("rd_b_valid", {31'd0, inst_valid}, 32'd0);
    chk("rd_b_inst",  inst, NOP);
    chk("rd_b_addr",  imem.imem_addr, 32'h4000_0100);
    chk("rd_b_cnt",   fetch_count, 32'd4);
    step(0, 0, 0);
    chk("rd_t_pc",   inst_pc, 32'h4000_0100);
    chk("rd_t_inst", inst, 32'h4000_0100);

    // Back-to-back redirects: latest target wins
    step(0, 1, 32'h5000_0000);
    step(0, 1, 32'h6000_0008);
    chk("rr_en",    {31'd0, imem.imem_en}, 32'd0);
    chk("rr_valid", {31'd0, inst_valid}, 32'd0);
    step(0, 0, 0);
    chk("rr_addr",  imem.imem_addr, 32'h6000_0008);
    step(0, 0, 0);
    chk("rr_pc",    inst_pc, 32'h6000_0008);

    // Redirect together with stall: stall ignored, target fetched once stall drops
    step(1, 1, 32'h4000_0200);
    chk("rs_en", {31'd0, imem.imem_en}, 32'd0);
    step(1, 0, 0);
    chk("rs_valid", {31'd0, inst_valid}, 32'd0);
    chk("rs_addr",  imem.imem_addr, 32'h4000_0200);
    chk("rs_en2",   {31'd0, imem.imem_en}, 32'd0);
    step(1, 0, 0);
    chk("rs_addr2", imem.imem_addr, 32'h4000_0200);
    step(0, 0, 0);
    chk("rs_en3", {31'd0, imem.imem_en}, 32'd1);
    step(0, 0, 0);
    chk("rs_pc",    inst_pc, 32'h4000_0200);
    chk("rs_valid2", {31'd0, inst_valid}, 32'd1);

    // PC wrap at top of address space
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wr_pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wr_addr1", imem.imem_addr, 32'h0000_0000);
    step(0, 0, 0);
    chk("wr_pc1", inst_pc, 32'h0000_0000);

    // Reset asserted while stalled: outputs drop immediately
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rs_pre_valid", {31'd0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_en",    {31'd0, imem.imem_en}, 32'd0);
    chk("mr_addr",  imem.imem_addr, RST);
    chk("mr_inst",  inst, NOP);
    chk("mr_pc",    inst_pc, 32'h0);
    chk("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk("mr_cnt",   fetch_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
